filter_window_sequencer: RTL
============================

Name: filter_window_sequencer

Overview:
Control sequencer for the image-filtering datapath's sliding 3x3 window over one shared single-port pixel memory. Scans an IMG_W x IMG_H input image at in_base in raster order (valid positions only, no padding). Per window: fetches pixels, hands the window to the MAC datapath, writes one result per output position to out_base. It replaces hand-sequenced counter enables with one FSM plus row/col counters.

Parameters:
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)
ADDR_W, 7, memory address width; all address arithmetic is modulo 2^ADDR_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a frame when idle
in_base  in  ADDR_W  input image base address, sampled on accepted start
out_base  in  ADDR_W  output image base address, sampled on accepted start
mac_done  in  1  datapath result ready (one-cycle pulse)
mem_addr  out  ADDR_W  shared memory address
mem_rd  out  1  memory read strobe; data valid next cycle
mem_wr  out  1  memory write strobe (datapath drives write data)
pix_we  out  1  capture memory read data into column staging register
pix_row  out  2  staging row (0..2) for pix_we
col_push  out  1  shift staged column into window (window shifts left)
mac_start  out  1  one-cycle pulse; window complete, begin MAC
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state IDLE; all outputs 0; counters and sampled bases cleared. Async reset mid-frame aborts immediately, with no further memory access.
- Accepted start: start=1 in IDLE. Samples bases and clears row r, col c, out_idx. start is ignored while busy.
- States: IDLE -> FILL -> DRAIN -> COMPUTE -> WRITE -> {SLIDE -> DRAIN | FILL | FIN} ; FIN -> IDLE.
- FILL (column 0 of each output row): 9 consecutive mem_rd cycles, column-major. Read addresses are in_base + (r+i)*IMG_W + (c+j), with j=0..2 as the outer loop and i=0..2 as the inner loop.
- SLIDE: 3 mem_rd cycles for the new column j=2 at c+2, rows i=0..2.
- Read pipeline: a mem_rd in cycle t gives pix_we=1 in cycle t+1, with pix_row=i of that read. col_push=1 in the same cycle as pix_we for pix_row=2.
- DRAIN: exactly one cycle after the last read, so that the final pix_we/col_push lands. Then go to COMPUTE.
- COMPUTE: mac_start=1 in the first cycle only, then wait for mac_done. mac_done is honoured only in COMPUTE and only from the cycle after mac_start; otherwise it is ignored.
- WRITE: one cycle with mem_wr=1 and mem_addr = out_base + out_idx. out_idx then increments.
- After WRITE:
  - If c < IMG_W-3: c++ and go to SLIDE.
  - Else if r < IMG_H-3: r++, c=0, go to FILL.
  - Else go to FIN.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE. A start in the FIN cycle is ignored.
- mem_rd and mem_wr are never high together. mem_addr=0 when neither strobe is high.
- Totals per frame: (IMG_W-2)*(IMG_H-2) writes, and (IMG_H-2)*(9+3*(IMG_W-3)) reads.
- Address overflow wraps modulo 2^ADDR_W. There is no error flag.

Optional Feature:
FILTER_PERF_CNT_EN. When defined: adds output perf_cycles [15:0]. It counts cycles with busy=1, is cleared on accepted start, holds after done, and saturates at 16'hFFFF. When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package filter_pkg: state enum (IDLE, FILL, SLIDE, DRAIN, COMPUTE, WRITE, FIN), default IMG_W/IMG_H/ADDR_W constants, and KSIZE=3.
- One natural sub-module, filter_addr_gen: r/c/i/j/out_idx counters and modulo address computation, driven by FSM advance/clear strobes.

Test Plan:
- 8x8 frame, in_base=0, out_base=64, mac_done 2 cycles after mac_start -> first 9 read addrs 0,8,16,1,9,17,2,10,18; next SLIDE reads 3,11,19; 36 writes at 64..99 in order; 144 reads; one done pulse.
- in_base=120 -> second read addr 0 (128 mod 128), first column reads 120,0,8; no X on mem_addr.
- mac_done delayed 5 cycles; spurious mac_done pulse during FILL -> FSM stalls in COMPUTE until the real pulse; spurious pulse ignored; write count still 36.
- start pulsed during busy and in the FIN cycle -> ignored; exactly one frame, one done.
- rst asserted during third SLIDE -> all outputs 0 asynchronously; a new start then reproduces the first scenario's sequence exactly.
- FILTER_PERF_CNT_EN defined, mac latency 2 -> perf_cycles equals the counted busy cycles from the bench monitor; holds after done.

Source files
------------

// File: rtl/filter_pkg.sv
// filter_pkg: shared state encoding and default geometry for the
// 3x3 sliding-window sequencer (top + address generator).
package filter_pkg;

    localparam int IMG_W_DEF  = 8;
    localparam int IMG_H_DEF  = 8;
    localparam int ADDR_W_DEF = 7;
    localparam int KSIZE      = 3;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SLIDE,
        DRAIN,
        COMPUTE,
        WRITE,
        FIN
    } state_e;

    // Index of the last row/column inside the kernel window.
    function automatic logic [1:0] klast();
        return 2'(KSIZE - 1);
    endfunction

endpackage

// File: rtl/filter_addr_gen.sv
// filter_addr_gen: window position counters (r, c), in-window read
// counters (i, j), output index, and modulo-2^ADDR_W address math.
// Ports:
//   clk, rst              clock, async active-high reset
//   clr_i                 frame start: sample bases, zero all counters
//   in_base_i/out_base_i  image bases, captured on clr_i
//   rd_adv_i              a read was issued this cycle
//   wr_adv_i              a result was written this cycle
//   rd_addr_o/wr_addr_o   current read / write address
//   row_sel_o             kernel row i of the current read
//   rd_last_o             current read is the last of its window
//   col_last_o/row_last_o window sits in the last column / row
module filter_addr_gen
    import filter_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] in_base_i,
    input  logic [ADDR_W-1:0] out_base_i,
    input  logic              rd_adv_i,
    input  logic              wr_adv_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [1:0]        row_sel_o,
    output logic              rd_last_o,
    output logic              col_last_o,
    output logic              row_last_o
);

    localparam logic [ADDR_W-1:0] W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] CMAX = ADDR_W'(IMG_W - KSIZE);
    localparam logic [ADDR_W-1:0] RMAX = ADDR_W'(IMG_H - KSIZE);

    logic [ADDR_W-1:0] r_q, r_d;
    logic [ADDR_W-1:0] c_q, c_d;
    logic [ADDR_W-1:0] oi_q, oi_d;
    logic [ADDR_W-1:0] inb_q, inb_d;
    logic [ADDR_W-1:0] outb_q, outb_d;
    logic [1:0]        i_q, i_d;
    logic [1:0]        j_q, j_d;

    always_comb begin
        r_d    = r_q;
        c_d    = c_q;
        oi_d   = oi_q;
        inb_d  = inb_q;
        outb_d = outb_q;
        i_d    = i_q;
        j_d    = j_q;
        if (clr_i) begin
            r_d    = '0;
            c_d    = '0;
            oi_d   = '0;
            inb_d  = in_base_i;
            outb_d = out_base_i;
            i_d    = '0;
            j_d    = '0;
        end else if (rd_adv_i) begin
            // Column-major: i (row) is the fast index.
            if (i_q == klast()) begin
                i_d = '0;
                j_d = j_q + 2'd1;
            end else begin
                i_d = i_q + 2'd1;
            end
        end else if (wr_adv_i) begin
            oi_d = oi_q + ADDR_W'(1);
            i_d  = '0;
            if (!col_last_o) begin
                // Slide: only the new right-hand column is fetched.
                c_d = c_q + ADDR_W'(1);
                j_d = klast();
            end else if (!row_last_o) begin
                r_d = r_q + ADDR_W'(1);
                c_d = '0;
                j_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            c_q    <= '0;
            oi_q   <= '0;
            inb_q  <= '0;
            outb_q <= '0;
            i_q    <= '0;
            j_q    <= '0;
        end else begin
            r_q    <= r_d;
            c_q    <= c_d;
            oi_q   <= oi_d;
            inb_q  <= inb_d;
            outb_q <= outb_d;
            i_q    <= i_d;
            j_q    <= j_d;
        end
    end

    // All terms are ADDR_W wide, so overflow wraps naturally.
    assign rd_addr_o = inb_q
                     + (r_q + ADDR_W'(i_q)) * W_A
                     + c_q + ADDR_W'(j_q);
    assign wr_addr_o = outb_q + oi_q;

    assign row_sel_o  = i_q;
    assign rd_last_o  = (i_q == klast()) && (j_q == klast());
    assign col_last_o = (c_q >= CMAX);
    assign row_last_o = (r_q >= RMAX);

endmodule

// File: rtl/filter_window_sequencer.sv
// filter_window_sequencer: FSM scanning a 3x3 window over an
// IMG_W x IMG_H image in one shared single-port memory.
// Ports:
//   clk, rst            clock, async active-high reset
//   start               begin a frame (accepted only in IDLE)
//   in_base/out_base    image bases, sampled on accepted start
//   mac_done            datapath result ready pulse
//   mem_addr/rd/wr      shared memory access (addr 0 when idle)
//   pix_we/pix_row      capture read data into staging row
//   col_push            shift staged column into the window
//   mac_start           window complete, start MAC
//   busy/done           frame in progress / frame end pulse
//   perf_cycles         busy-cycle count, only with
//                       FILTER_PERF_CNT_EN defined
module filter_window_sequencer
    import filter_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic              mac_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              pix_we,
    output logic [1:0]        pix_row,
    output logic              col_push,
    output logic              mac_start,
    output logic              busy,
    output logic              done
`ifdef FILTER_PERF_CNT_EN
   ,output logic [15:0]       perf_cycles
`endif
);

    state_e            state_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              pix_we_q;
    logic [1:0]        pix_row_q;
    logic              col_push_q;
    logic              mac_start_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        row_sel;
    logic              rd_last;
    logic              col_last;
    logic              row_last;

    assign accept = (state_q == IDLE) && start;

    filter_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .in_base_i  (in_base),
        .out_base_i (out_base),
        .rd_adv_i   (mem_rd_q),
        .wr_adv_i   (mem_wr_q),
        .rd_addr_o  (rd_addr),
        .wr_addr_o  (wr_addr),
        .row_sel_o  (row_sel),
        .rd_last_o  (rd_last),
        .col_last_o (col_last),
        .row_last_o (row_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            pix_we_q    <= 1'b0;
            pix_row_q   <= '0;
            col_push_q  <= 1'b0;
            mac_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Read data arrives one cycle after the strobe.
            pix_we_q    <= mem_rd_q;
            pix_row_q   <= mem_rd_q ? row_sel : 2'd0;
            col_push_q  <= mem_rd_q && (row_sel == klast());
            mac_start_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= FILL;
                        mem_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                FILL, SLIDE: begin
                    if (rd_last) begin
                        state_q  <= DRAIN;
                        mem_rd_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    state_q     <= COMPUTE;
                    mac_start_q <= 1'b1;
                end
                COMPUTE: begin
                    // A pulse coinciding with mac_start is stale.
                    if (mac_done && !mac_start_q) begin
                        state_q  <= WRITE;
                        mem_wr_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (!col_last) begin
                        state_q  <= SLIDE;
                        mem_rd_q <= 1'b1;
                    end else if (!row_last) begin
                        state_q  <= FILL;
                        mem_rd_q <= 1'b1;
                    end else begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_rd_q ? rd_addr :
                       mem_wr_q ? wr_addr : '0;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign pix_we    = pix_we_q;
    assign pix_row   = pix_row_q;
    assign col_push  = col_push_q;
    assign mac_start = mac_start_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef FILTER_PERF_CNT_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
